// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a shared single-port
// word RAM with registered read: every access runs IDLE -> ACCESS -> CAPTURE.
module ram_arbiter #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 16
) (
  input  logic              cl,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_st,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_x,
  input  logic [DATA_W-1:0] ram_y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                g_q, g_d;            // index of the requester being served
  logic                we_q, we_d;
  logic                last_q, last_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                ram_st_q, ram_st_d;
  logic [ADDR_W-1:0]   ram_ad_q, ram_ad_d;
  logic [DATA_W-1:0]   ram_x_q, ram_x_d;

  logic                elig0, elig1, gnt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d  = state_q;
    g_d      = g_q;
    we_d     = we_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ram_st_d = 1'b0;
    ram_ad_d = ram_ad_q;
    ram_x_d  = ram_x_q;
    // A requester acked this cycle is skipped so its still-high req is not re-granted.
    elig0    = req0 & ~ack0_q;
    elig1    = req1 & ~ack1_q;
    gnt      = (elig0 && elig1) ? ~last_q : elig1;

    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          state_d  = ACCESS;
          g_d      = gnt;
          last_d   = gnt;
          we_d     = gnt ? we1    : we0;
          ram_st_d = gnt ? we1    : we0;
          ram_ad_d = gnt ? addr1  : addr0;
          ram_x_d  = gnt ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (g_q) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = ram_y;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = ram_y;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge cl or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      g_q      <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ram_st_q <= 1'b0;
      ram_ad_q <= '0;
      ram_x_q  <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      we_q     <= we_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ram_st_q <= ram_st_d;
      ram_ad_q <= ram_ad_d;
      ram_x_q  <= ram_x_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);
  assign ram_st = ram_st_q;
  assign ram_ad = ram_ad_q;
  assign ram_x  = ram_x_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, corner-case sequences,
// and randomized traffic compared against a transaction-level model with a 2-word RAM.
module tb_ram_arbiter;

  logic        cl = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [0:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, ram_st;
  logic [15:0] rdata0, rdata1, ram_x;
  logic [0:0]  ram_ad;
  logic [15:0] ram_y = '0;
  logic [15:0] tb_mem [2] = '{16'h0000, 16'h0000};

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_W(1), .DATA_W(16)) dut (
    .cl(cl), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .ram_st(ram_st), .ram_ad(ram_ad), .ram_x(ram_x), .ram_y(ram_y)
  );

  always #5 cl = ~cl;

  // Shared RAM: store on st, registered read of the presented address.
  always @(posedge cl) begin
    if (ram_st) tb_mem[ram_ad] <= ram_x;
    ram_y <= tb_mem[ram_ad];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_outs();
    return {11'b0, ack0, ack1, rdata0, rdata1, busy, ram_st, ram_ad, ram_x};
  endfunction

  // ---------------- transaction-level reference model ----------------
  int          m_left;          // remaining busy cycles of the access in flight
  logic        m_g, m_we, m_last, m_ad;
  logic [15:0] m_x;
  logic [1:0]  m_ack;
  logic [15:0] m_rdata [2];
  logic [15:0] m_mem   [2];

  task automatic model_reset();
    m_left = 0; m_g = 1'b0; m_we = 1'b0; m_last = 1'b1; m_ad = 1'b0;
    m_x = '0; m_ack = 2'b00; m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  // Called at each rising edge with the inputs presented during the cycle before it.
  task automatic model_edge();
    logic [1:0] new_ack;
    logic       e0, e1;
    int         g;
    new_ack = 2'b00;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        new_ack[m_g] = 1'b1;
        if (!m_we) m_rdata[m_g] = m_mem[m_ad];
      end
    end else begin
      e0 = req0 && !m_ack[0];
      e1 = req1 && !m_ack[1];
      if (e0 || e1) begin
        if (e0 && e1) g = m_last ? 0 : 1;
        else          g = e1 ? 1 : 0;
        m_g    = (g == 1);
        m_last = m_g;
        m_we   = m_g ? we1    : we0;
        m_ad   = m_g ? addr1  : addr0;
        m_x    = m_g ? wdata1 : wdata0;
        if (m_we) m_mem[m_ad] = m_x;
        m_left = 2;
      end
    end
    m_ack = new_ack;
  endtask

  function automatic logic [63:0] model_outs();
    return {11'b0, m_ack[0], m_ack[1], m_rdata[0], m_rdata[1],
            (m_left > 0), (m_left == 2) && m_we, m_ad, m_x};
  endfunction

  // ---------------- helpers ----------------
  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge cl);
    clear_inputs();
    rst = 1'b1;
    @(negedge cl);
    rst = 1'b0;
  endtask

  task automatic wait_ack0(input int exp_lat, input string name);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge cl); @(negedge cl);
      cyc++;
      if (ack0) break;
    end
    check(name, 64'(cyc), 64'(exp_lat));
  endtask

  typedef struct {
    logic        r0, w0, a0; logic [15:0] d0;
    logic        r1, w1, a1; logic [15:0] d1;
    logic        k0, k1; logic [15:0] q0, q1;
    logic        bz, st, ad; logic [15:0] x;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, a0, input logic [15:0] d0,
                              input logic r1, w1, a1, input logic [15:0] d1,
                              input logic k0, k1, input logic [15:0] q0, q1,
                              input logic bz, st, ad, input logic [15:0] x);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.k0 = k0; v.k1 = k1; v.q0 = q0; v.q1 = q1;
    v.bz = bz; v.st = st; v.ad = ad; v.x = x;
    return v;
  endfunction

  vec_t vecs [10];

  initial begin
    // Outputs after each edge: write 0:A5A5 (req0), write 1:1234 (req1), read 1 (req0).
    vecs[0] = mk(1,1,0,16'hA5A5, 0,0,0,16'h0000, 0,0,16'h0000,16'h0000, 1,1,0,16'hA5A5);
    vecs[1] = mk(1,1,0,16'hA5A5, 0,0,0,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'hA5A5);
    vecs[2] = mk(1,1,0,16'hA5A5, 0,0,0,16'h0000, 1,0,16'h0000,16'h0000, 0,0,0,16'hA5A5);
    vecs[3] = mk(0,0,0,16'h0000, 1,1,1,16'h1234, 0,0,16'h0000,16'h0000, 1,1,1,16'h1234);
    vecs[4] = mk(0,0,0,16'h0000, 1,1,1,16'h1234, 0,0,16'h0000,16'h0000, 1,0,1,16'h1234);
    vecs[5] = mk(0,0,0,16'h0000, 1,1,1,16'h1234, 0,1,16'h0000,16'h0000, 0,0,1,16'h1234);
    vecs[6] = mk(1,0,1,16'hFFFF, 0,0,0,16'h0000, 0,0,16'h0000,16'h0000, 1,0,1,16'hFFFF);
    vecs[7] = mk(1,0,1,16'hFFFF, 0,0,0,16'h0000, 0,0,16'h0000,16'h0000, 1,0,1,16'hFFFF);
    vecs[8] = mk(1,0,1,16'hFFFF, 0,0,0,16'h0000, 1,0,16'h1234,16'h0000, 0,0,1,16'hFFFF);
    vecs[9] = mk(0,0,0,16'h0000, 0,0,0,16'h0000, 0,0,16'h1234,16'h0000, 0,0,1,16'hFFFF);

    // Reset state, checked while reset is held.
    @(negedge cl);
    clear_inputs();
    rst = 1'b1;
    #1;
    check("reset_outputs", pack_outs(), 64'h0);
    @(negedge cl);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(posedge cl); @(negedge cl);
      check($sformatf("vec%0d", i), pack_outs(),
            {11'b0, vecs[i].k0, vecs[i].k1, vecs[i].q0, vecs[i].q1,
             vecs[i].bz, vecs[i].st, vecs[i].ad, vecs[i].x});
    end

    // Request fields changed after grant must not reach the RAM.
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 16'h1111;
    @(posedge cl); @(negedge cl);
    check("latch_access", {46'b0, ram_st, ram_ad, ram_x}, {46'b0, 1'b1, 1'b0, 16'h1111});
    addr0 = 1; wdata0 = 16'h2222;
    @(posedge cl); @(negedge cl);
    check("latch_capture", {46'b0, ram_st, ram_ad, ram_x}, {46'b0, 1'b0, 1'b0, 16'h1111});
    @(posedge cl); @(negedge cl);
    check("latch_ack", {63'b0, ack0}, 64'h1);
    req0 = 0;
    @(posedge cl); @(negedge cl);
    req0 = 1; we0 = 0; addr0 = 0;
    wait_ack0(3, "readback0_latency");
    check("readback0_data", {48'b0, rdata0}, {48'b0, 16'h1111});
    req0 = 0;
    @(posedge cl); @(negedge cl);
    req0 = 1; we0 = 0; addr0 = 1;
    wait_ack0(3, "readback1_latency");
    check("readback1_data", {48'b0, rdata0}, {48'b0, 16'h1234});
    req0 = 0;
    @(posedge cl); @(negedge cl);

    // Reset during ACCESS of a write: everything clears at once, no ack.
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 16'hBEEF;
    @(posedge cl);
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", pack_outs(), 64'h0);
    @(negedge cl);
    clear_inputs();
    rst = 1'b0;
    req0 = 1; we0 = 0; addr0 = 1;
    wait_ack0(3, "post_reset_latency");
    check("post_reset_data", {48'b0, rdata0}, {48'b0, 16'h1234});

    // Both requesters held from reset: strict alternation, acks 3 cycles apart.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 0;
    req1 = 1; we1 = 0; addr1 = 1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge cl); @(negedge cl);
      check($sformatf("alt_k%0d", k), {62'b0, ack0, ack1},
            {62'b0, (k % 6 == 3), (k % 6 == 0)});
    end

    // req0 alone and held: skipped in its ack cycle, regranted the cycle after.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge cl); @(negedge cl);
      check($sformatf("solo_k%0d", k), {62'b0, ack0, busy},
            {62'b0, (k % 4 == 3), (k % 4 == 1) || (k % 4 == 2)});
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    m_mem[0] = tb_mem[0];
    m_mem[1] = tb_mem[1];
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("rand_c%0d", c), pack_outs(), model_outs());
      req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
      addr0 = 1'($urandom_range(0, 1)); wdata0 = 16'($urandom);
      req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      addr1 = 1'($urandom_range(0, 1)); wdata1 = 16'($urandom);
      @(posedge cl);
      model_edge();
      @(negedge cl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
